// File: rtl/bcd_gray_arb.sv
// bcd_gray_arb: round-robin front end for one shared combinational
// BCD-to-Gray converter. Two requesters hand over a digit on a valid/ready
// handshake. The winner's digit is range-checked and then driven onto the
// converter with enable held for SETTLE cycles. The sampled Gray code goes
// back out with the requester id and an error flag.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   req{0,1}_valid/bcd/ready requester handshakes (ready is combinational, IDLE only)
//   conv_bcd, conv_en        drive to the shared converter (registered)
//   conv_gray                converter result
//   rsp_valid/ready          result handshake; rsp_gray/id/err held while pending
//   busy                     state != IDLE
//   conv_count               completed conversions, wraps
module bcd_gray_arb #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [3:0]       req0_bcd,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_bcd,
    output logic             req1_ready,
    output logic [3:0]       conv_bcd,
    output logic             conv_en,
    input  logic [3:0]       conv_gray,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_gray,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] conv_count
);

    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

    // Counter is loaded with SETTLE-1 so that reaching zero marks the
    // SETTLE-th enabled cycle, which is the cycle the result is sampled in.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic       ptr;        // requester that wins a tie
    logic [3:0] settle_cnt;
    logic       grant_vld;
    logic       grant_id;
    logic [3:0] grant_bcd;

    // The priority requester wins if it is asking; otherwise the other one does.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (ptr == 1'b0) grant_id = req0_valid ? 1'b0 : 1'b1;
        else             grant_id = req1_valid ? 1'b1 : 1'b0;
        grant_bcd = grant_id ? req1_bcd : req0_bcd;
    end

    // Ready is held low while rst is high so that all outputs read 0 in reset.
    assign req0_ready = !rst && (state == IDLE) && grant_vld && !grant_id;
    assign req1_ready = !rst && (state == IDLE) && grant_vld &&  grant_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            settle_cnt <= '0;
            conv_bcd   <= '0;
            conv_en    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_gray   <= '0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            conv_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        ptr    <= ~ptr;
                        rsp_id <= grant_id;
                        busy   <= 1'b1;
                        if (grant_bcd > 4'd9) begin
                            // Not a BCD digit: report the error without
                            // touching the converter.
                            rsp_err   <= 1'b1;
                            rsp_gray  <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            conv_en    <= 1'b1;
                            conv_bcd   <= grant_bcd;
                            settle_cnt <= SETTLE_LAST;
                            state      <= CONV;
                        end
                    end
                end
                CONV: begin
                    if (settle_cnt == 4'd0) begin
                        conv_en    <= 1'b0;
                        conv_bcd   <= '0;
                        rsp_gray   <= conv_gray;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        conv_count <= conv_count + CNT_W'(1);
                        state      <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_gray  <= '0;
                        rsp_id    <= 1'b0;
                        rsp_err   <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_gray_arb.sv
// Directed bench for bcd_gray_arb. One instance is built with SETTLE=1 and a
// second with SETTLE=4. Each instance has a behavioural converter attached.
module tb_bcd_gray_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SETTLE=1 instance
    logic       rst, r0_valid, r0_ready, r1_valid, r1_ready;
    logic [3:0] r0_bcd, r1_bcd, c_bcd, c_gray, rsp_gray;
    logic       c_en, rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [7:0] cnt;

    assign c_gray = c_en ? {c_bcd[3], c_bcd[3]^c_bcd[2], c_bcd[2]^c_bcd[1], c_bcd[1]^c_bcd[0]} : 4'b0;

    bcd_gray_arb #(.SETTLE(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0_valid), .req0_bcd(r0_bcd), .req0_ready(r0_ready),
        .req1_valid(r1_valid), .req1_bcd(r1_bcd), .req1_ready(r1_ready),
        .conv_bcd(c_bcd), .conv_en(c_en), .conv_gray(c_gray),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_gray(rsp_gray),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy), .conv_count(cnt)
    );

    // SETTLE=4 instance
    logic       rst4, s0_valid, s0_ready, s1_valid, s1_ready;
    logic [3:0] s0_bcd, s1_bcd, s_bcd, s_gray, s_rsp_gray;
    logic       s_en, s_rsp_valid, s_rsp_ready, s_rsp_id, s_rsp_err, s_busy;
    logic [7:0] s_cnt;

    assign s_gray = s_en ? {s_bcd[3], s_bcd[3]^s_bcd[2], s_bcd[2]^s_bcd[1], s_bcd[1]^s_bcd[0]} : 4'b0;

    bcd_gray_arb #(.SETTLE(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst4),
        .req0_valid(s0_valid), .req0_bcd(s0_bcd), .req0_ready(s0_ready),
        .req1_valid(s1_valid), .req1_bcd(s1_bcd), .req1_ready(s1_ready),
        .conv_bcd(s_bcd), .conv_en(s_en), .conv_gray(s_gray),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_gray(s_rsp_gray),
        .rsp_id(s_rsp_id), .rsp_err(s_rsp_err), .busy(s_busy), .conv_count(s_cnt)
    );

    task automatic test_reset();
        @(negedge clk);
        r0_valid = 1'b1;  // readys must stay low in reset even with a request
        #1;
        checks++; if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {r0_ready, r1_ready}); end
        checks++; if ({c_bcd, c_en, busy} !== 6'b0) begin errors++; $display("FAIL reset_conv got %b exp 0", {c_bcd, c_en, busy}); end
        checks++; if ({rsp_valid, rsp_gray, rsp_id, rsp_err} !== 7'b0) begin errors++; $display("FAIL reset_rsp got %b exp 0", {rsp_valid, rsp_gray, rsp_id, rsp_err}); end
        checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt); end
        r0_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        r0_valid = 1'b1; r0_bcd = 4'b0111; #1;
        checks++; if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("FAIL single_grant got %b exp 10", {r0_ready, r1_ready}); end
        @(negedge clk);
        r0_valid = 1'b0;
        checks++; if ({c_en, c_bcd} !== 5'b1_0111) begin errors++; $display("FAIL single_conv got %b exp 10111", {c_en, c_bcd}); end
        checks++; if ({rsp_valid, busy} !== 2'b01) begin errors++; $display("FAIL single_busy got %b exp 01", {rsp_valid, busy}); end
        @(negedge clk);
        checks++; if ({c_en, c_bcd} !== 5'b0) begin errors++; $display("FAIL single_conv_off got %b exp 00000", {c_en, c_bcd}); end
        checks++; if ({rsp_valid, rsp_gray, rsp_id, rsp_err} !== 7'b1_0100_0_0) begin errors++; $display("FAIL single_rsp got %b exp 1010000", {rsp_valid, rsp_gray, rsp_id, rsp_err}); end
        checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL single_count got %0d exp 1", cnt); end
        @(negedge clk);
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_idle got %b exp 00", {rsp_valid, busy}); end
    endtask

    // Both requesters valid continuously; also checks the back-to-back spacing.
    task automatic test_contention();
        int prev;
        logic seen;
        logic exp_id;
        prev = 0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        r0_valid = 1'b1; r0_bcd = 4'b0011;
        r1_valid = 1'b1; r1_bcd = 4'b1001;
        for (int k = 0; k < 6; k++) begin
            exp_id = k[0];
            seen = 1'b0;
            for (int t = 0; t < 10 && !seen; t++) begin
                #1;
                checks++; if (r0_ready && r1_ready) begin errors++; $display("FAIL cont_two_readys got 11 exp one-hot"); end
                if (r0_ready || r1_ready) seen = 1'b1;
                else @(negedge clk);
            end
            checks++; if (!seen) begin errors++; $display("FAIL cont_grant_timeout k=%0d got none exp grant", k); end
            checks++; if (r1_ready !== exp_id) begin errors++; $display("FAIL cont_grant_id k=%0d got %b exp %b", k, r1_ready, exp_id); end
            if (k > 0) begin
                checks++; if (cyc - prev !== 3) begin errors++; $display("FAIL cont_spacing k=%0d got %0d exp 3", k, cyc - prev); end
            end
            prev = cyc;
            seen = 1'b0;
            for (int t = 0; t < 10 && !seen; t++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1'b1;
            end
            checks++; if (!seen) begin errors++; $display("FAIL cont_rsp_timeout k=%0d got none exp rsp", k); end
            checks++; if ({rsp_gray, rsp_id, rsp_err} !== (exp_id ? 6'b1101_1_0 : 6'b0010_0_0)) begin
                errors++; $display("FAIL cont_rsp k=%0d got %b exp %b", k, {rsp_gray, rsp_id, rsp_err}, (exp_id ? 6'b1101_1_0 : 6'b0010_0_0)); end
            checks++; if (cnt !== 8'(k + 1)) begin errors++; $display("FAIL cont_count k=%0d got %0d exp %0d", k, cnt, k + 1); end
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
    endtask

    task automatic test_invalid();
        @(negedge clk);
        r1_valid = 1'b1; r1_bcd = 4'b1100; #1;
        checks++; if ({r0_ready, r1_ready} !== 2'b01) begin errors++; $display("FAIL inv_grant got %b exp 01", {r0_ready, r1_ready}); end
        @(negedge clk);
        r1_valid = 1'b0;
        checks++; if (c_en !== 1'b0) begin errors++; $display("FAIL inv_conv_en got %b exp 0", c_en); end
        checks++; if ({rsp_valid, rsp_gray, rsp_id, rsp_err} !== 7'b1_0000_1_1) begin errors++; $display("FAIL inv_rsp got %b exp 1000011", {rsp_valid, rsp_gray, rsp_id, rsp_err}); end
        checks++; if (cnt !== 8'd6) begin errors++; $display("FAIL inv_count got %0d exp 6", cnt); end
        @(negedge clk);
        checks++; if ({rsp_valid, c_en} !== 2'b00) begin errors++; $display("FAIL inv_idle got %b exp 00", {rsp_valid, c_en}); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        r0_valid = 1'b1; r0_bcd = 4'b0101; #1;
        checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL bp_grant got %b exp 1", r0_ready); end
        @(negedge clk);
        r1_valid = 1'b1; r1_bcd = 4'b0001;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if ({rsp_valid, rsp_gray, rsp_id, rsp_err, busy} !== 8'b1_0111_0_0_1) begin
                errors++; $display("FAIL bp_hold i=%0d got %b exp 10111001", i, {rsp_valid, rsp_gray, rsp_id, rsp_err, busy}); end
            checks++; if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("FAIL bp_readys i=%0d got %b exp 00", i, {r0_ready, r1_ready}); end
        end
        rsp_ready = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        @(negedge clk);
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_release got %b exp 00", {rsp_valid, busy}); end
        checks++; if (cnt !== 8'd7) begin errors++; $display("FAIL bp_count got %0d exp 7", cnt); end
    endtask

    task automatic test_settle4();
        int en_cnt;
        int rsp_at;
        en_cnt = 0;
        rsp_at = 0;
        checks++; if ({s_en, s_rsp_valid, s_busy, s_cnt} !== 11'b0) begin errors++; $display("FAIL s4_reset got %b exp 0", {s_en, s_rsp_valid, s_busy, s_cnt}); end
        rst4 = 1'b0;
        @(negedge clk);
        s0_valid = 1'b1; s0_bcd = 4'b0101; #1;
        checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL s4_grant got %b exp 1", s0_ready); end
        @(negedge clk);
        s0_valid = 1'b0;
        for (int t = 1; t <= 10 && rsp_at == 0; t++) begin
            if (s_en) begin
                en_cnt++;
                checks++; if (s_bcd !== 4'b0101) begin errors++; $display("FAIL s4_conv_bcd t=%0d got %b exp 0101", t, s_bcd); end
            end
            if (s_rsp_valid) rsp_at = t;
            else @(negedge clk);
        end
        checks++; if (en_cnt !== 4) begin errors++; $display("FAIL s4_en_cycles got %0d exp 4", en_cnt); end
        checks++; if (rsp_at !== 5) begin errors++; $display("FAIL s4_latency got %0d exp 5", rsp_at); end
        checks++; if ({s_rsp_gray, s_rsp_id, s_rsp_err} !== 6'b0111_0_0) begin errors++; $display("FAIL s4_rsp got %b exp 011100", {s_rsp_gray, s_rsp_id, s_rsp_err}); end
        checks++; if (s_cnt !== 8'd1) begin errors++; $display("FAIL s4_count got %0d exp 1", s_cnt); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        r1_valid = 1'b1; r1_bcd = 4'b0011; #1;
        checks++; if (r1_ready !== 1'b1) begin errors++; $display("FAIL ar_grant got %b exp 1", r1_ready); end
        @(negedge clk);
        r1_valid = 1'b0;
        checks++; if (c_en !== 1'b1) begin errors++; $display("FAIL ar_in_conv got %b exp 1", c_en); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({c_en, c_bcd, busy, rsp_valid, rsp_gray, rsp_id, rsp_err} !== 13'b0) begin
            errors++; $display("FAIL ar_outputs got %b exp 0", {c_en, c_bcd, busy, rsp_valid, rsp_gray, rsp_id, rsp_err}); end
        checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", cnt); end
        @(negedge clk);
        rst = 1'b0;
        r0_valid = 1'b1; r0_bcd = 4'b0011;
        r1_valid = 1'b1; r1_bcd = 4'b1001;
        #1;
        checks++; if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("FAIL ar_first_grant got %b exp 10", {r0_ready, r1_ready}); end
        @(negedge clk);
        r0_valid = 1'b0; r1_valid = 1'b0;
        checks++; if ({c_en, c_bcd} !== 5'b1_0011) begin errors++; $display("FAIL ar_conv got %b exp 10011", {c_en, c_bcd}); end
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_gray, rsp_id, cnt} !== {1'b1, 4'b0010, 1'b0, 8'd1}) begin
            errors++; $display("FAIL ar_rsp got %b exp %b", {rsp_valid, rsp_gray, rsp_id, cnt}, {1'b1, 4'b0010, 1'b0, 8'd1}); end
    endtask

    initial begin
        rst = 1'b1; rst4 = 1'b1;
        r0_valid = 1'b0; r0_bcd = 4'b0; r1_valid = 1'b0; r1_bcd = 4'b0; rsp_ready = 1'b1;
        s0_valid = 1'b0; s0_bcd = 4'b0; s1_valid = 1'b0; s1_bcd = 4'b0; s_rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_invalid();
        test_backpressure();
        test_settle4();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
